rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter DW, default 8, register data width.
REQ-002 Parameter AW, default 4, register address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 core_req  input  1  control FSM requests one register-file write; held until core_gnt.
REQ-006 core_addr  input  AW  core destination register.
REQ-007 core_data  input  DW  core write data.
REQ-008 core_gnt  output  1  one-cycle pulse; core write committed this cycle.
REQ-009 dbg_req  input  1  debug/loader requests one write; held until dbg_gnt.
REQ-010 dbg_addr  input  AW  debug destination register.
REQ-011 dbg_data  input  DW  debug write data.
REQ-012 dbg_lock  input  1  debug requests exclusive ownership of the write port.
REQ-013 dbg_gnt  output  1  one-cycle pulse; debug write committed this cycle.
REQ-014 locked  output  1  high while in LOCK state.
REQ-015 rf_we  output  1  register-file write enable.
REQ-016 rf_waddr  output  AW  register-file write address.
REQ-017 rf_wdata  output  DW  register-file write data.
REQ-018 wr_cnt  output  8  count of committed writes, all requesters.

Function
REQ-019 The block SHALL implement states IDLE, WR_CORE, WR_DBG, LOCK.
REQ-020 All outputs SHALL be registered.
REQ-021 From IDLE with dbg_lock=1, the next state SHALL be LOCK, with no grant issued that cycle, even if core_req or dbg_req is high.
REQ-022 From IDLE with dbg_lock=0 and only core_req, the next state SHALL be WR_CORE; with only dbg_req, WR_DBG.
REQ-023 From IDLE with dbg_lock=0 and both requests high, the winner SHALL be the requester that did not win the previous arbitration (round-robin); after reset, core SHALL win first.
REQ-024 On entering WR_x, the block SHALL latch the winner's addr/data into rf_waddr/rf_wdata and SHALL drive rf_we=1 and x_gnt=1 for exactly that one cycle.
REQ-025 Latency from req sampled high in IDLE to rf_we SHALL be exactly one cycle.
REQ-026 WR_CORE and WR_DBG SHALL always return to IDLE on the next cycle, so sustained throughput is one write per two cycles.
REQ-027 In LOCK, each dbg_req SHALL be serviced as a write (rf_we=1, dbg_gnt=1) on the following cycle, then the block SHALL return to LOCK; core_gnt SHALL stay 0.
REQ-028 In LOCK with dbg_lock=0 and no write in progress, the next state SHALL be IDLE and locked SHALL deassert on that edge.
REQ-029 Deasserting dbg_lock while a LOCK write is in progress SHALL complete the write before the block returns to IDLE.
REQ-030 Outside write cycles, rf_we SHALL be 0; rf_waddr/rf_wdata SHALL hold their last values.
REQ-031 wr_cnt SHALL increment by 1 for every cycle with rf_we=1 and SHALL wrap from 255 to 0.
REQ-032 A request deasserted before its grant SHALL be dropped without a write.
REQ-033 A requester that keeps req high after its gnt SHALL be treated as a new request.

Reset
REQ-034 reset_n=0 SHALL immediately force state=IDLE, rf_we=0, core_gnt=0, dbg_gnt=0, locked=0, rf_waddr=0, rf_wdata=0, wr_cnt=0, and round-robin pointer so core wins the next tie.
REQ-035 Reset asserted during any state, including mid-write or LOCK, SHALL abort that operation with no further grant pulses.
REQ-036 Release of reset_n SHALL take effect on the next rising edge of clk.

Verification
REQ-037 Reset release, core_req=1, addr=3, data=0x5A -> next cycle: rf_we=1, rf_waddr=3, rf_wdata=0x5A, core_gnt=1, wr_cnt=1.
REQ-038 core_req and dbg_req held high together for 8 cycles -> grants alternate core, dbg, core, dbg, one every 2 cycles; wr_cnt=4.
REQ-039 dbg_lock=1 with core_req held high, then 3 debug writes -> 3 dbg_gnt pulses, core_gnt=0 throughout; drop dbg_lock -> IDLE, then core granted.
REQ-040 Preload 255 writes, then perform one more write -> wr_cnt wraps to 0.
REQ-041 reset_n=0 asserted during WR_DBG -> rf_we and dbg_gnt drop asynchronously; after release, first tie goes to core.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. It arbitrates between the core control FSM and the debug/loader port.
// Ties go round-robin. Debug can lock the port for exclusive use, and every output is registered.
module rf_wr_arbiter #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          core_req,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_data,
   output logic          core_gnt,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_data,
   input  logic          dbg_lock,
   output logic          dbg_gnt,
   output logic          locked,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [7:0]    wr_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_CORE = 2'd1,
      WR_DBG  = 2'd2,
      LOCK    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          lock_wr_q, lock_wr_d;   // current WR_DBG belongs to a lock session
   logic          rr_dbg_q, rr_dbg_d;     // debug wins the next tie
   logic          rf_we_q, rf_we_d;
   logic          core_gnt_q, core_gnt_d;
   logic          dbg_gnt_q, dbg_gnt_d;
   logic          locked_q, locked_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic [7:0]    wr_cnt_q, wr_cnt_d;

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         lock_wr_q  <= 1'b0;
         rr_dbg_q   <= 1'b0;
         rf_we_q    <= 1'b0;
         core_gnt_q <= 1'b0;
         dbg_gnt_q  <= 1'b0;
         locked_q   <= 1'b0;
         rf_waddr_q <= {AW{1'b0}};
         rf_wdata_q <= {DW{1'b0}};
         wr_cnt_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         lock_wr_q  <= lock_wr_d;
         rr_dbg_q   <= rr_dbg_d;
         rf_we_q    <= rf_we_d;
         core_gnt_q <= core_gnt_d;
         dbg_gnt_q  <= dbg_gnt_d;
         locked_q   <= locked_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // Next-state, arbitration and round-robin pointer
   always_comb begin
      state_d   = state_q;
      lock_wr_d = lock_wr_q;
      rr_dbg_d  = rr_dbg_q;
      case (state_q)
         IDLE: begin
            lock_wr_d = 1'b0;
            if (dbg_lock) begin
               state_d = LOCK;
            end else if (core_req && (!dbg_req || !rr_dbg_q)) begin
               state_d  = WR_CORE;
               rr_dbg_d = 1'b1;
            end else if (dbg_req) begin
               state_d  = WR_DBG;
               rr_dbg_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         WR_CORE: begin
            state_d   = IDLE;
            lock_wr_d = 1'b0;
         end
         WR_DBG: begin
            // A lock write always finishes. It then returns to LOCK only if the lock is still held.
            if (lock_wr_q && dbg_lock) begin
               state_d = LOCK;
            end else begin
               state_d = IDLE;
            end
            lock_wr_d = 1'b0;
         end
         LOCK: begin
            if (dbg_req) begin
               state_d   = WR_DBG;
               lock_wr_d = 1'b1;
            end else if (!dbg_lock) begin
               state_d = IDLE;
            end else begin
               state_d = LOCK;
            end
         end
         default: begin
            state_d   = IDLE;
            lock_wr_d = 1'b0;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the state being entered
   always_comb begin
      rf_we_d    = 1'b0;
      core_gnt_d = 1'b0;
      dbg_gnt_d  = 1'b0;
      locked_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      case (state_d)
         WR_CORE: begin
            rf_we_d    = 1'b1;
            core_gnt_d = 1'b1;
            rf_waddr_d = core_addr;
            rf_wdata_d = core_data;
         end
         WR_DBG: begin
            rf_we_d    = 1'b1;
            dbg_gnt_d  = 1'b1;
            locked_d   = lock_wr_d;
            rf_waddr_d = dbg_addr;
            rf_wdata_d = dbg_data;
         end
         LOCK: begin
            locked_d = 1'b1;
         end
         IDLE: begin
            locked_d = 1'b0;
         end
         default: begin
            locked_d = 1'b0;
         end
      endcase
      wr_cnt_d = wr_cnt_q + {7'd0, rf_we_d};
   end

   assign rf_we    = rf_we_q;
   assign core_gnt = core_gnt_q;
   assign dbg_gnt  = dbg_gnt_q;
   assign locked   = locked_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter. It runs directed scenarios and then random requester traffic.
// Each cycle is compared against a behavioural write-port model.
module tb_rf_wr_arbiter;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          core_req, dbg_req, dbg_lock;
   logic [AW-1:0] core_addr, dbg_addr;
   logic [DW-1:0] core_data, dbg_data;
   logic          core_gnt, dbg_gnt, locked, rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [7:0]    wr_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: abstract view of the write port
   bit            m_we, m_cgnt, m_dgnt, m_lock, m_lockwr, m_core_next;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_cnt;

   rf_wr_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_gnt(core_gnt),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_lock(dbg_lock),
      .dbg_gnt(dbg_gnt), .locked(locked), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_we = 0; m_cgnt = 0; m_dgnt = 0; m_lock = 0; m_lockwr = 0; m_core_next = 1;
      m_addr = '0; m_data = '0; m_cnt = 0;
   endtask

   task automatic model_write(input bit is_core);
      m_we = 1;
      m_cgnt = is_core;
      m_dgnt = !is_core;
      m_addr = is_core ? core_addr : dbg_addr;
      m_data = is_core ? core_data : dbg_data;
      m_cnt  = (m_cnt + 1) % 256;
   endtask

   task automatic model_step();
      bit was_we;
      was_we = m_we;
      m_we = 0; m_cgnt = 0; m_dgnt = 0;
      if (was_we) begin
         m_lock   = m_lockwr && dbg_lock;
         m_lockwr = 0;
      end else if (m_lock) begin
         if (dbg_req) begin
            model_write(1'b0);
            m_lockwr = 1;
         end else if (!dbg_lock) begin
            m_lock = 0;
         end
      end else if (dbg_lock) begin
         m_lock = 1;
      end else if (core_req && (!dbg_req || m_core_next)) begin
         model_write(1'b1);
         m_core_next = 0;
      end else if (dbg_req) begin
         model_write(1'b0);
         m_core_next = 1;
      end
   endtask

   task automatic check_all();
      chk("rf_we", rf_we, m_we);
      chk("core_gnt", core_gnt, m_cgnt);
      chk("dbg_gnt", dbg_gnt, m_dgnt);
      chk("locked", locked, m_lock);
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("wr_cnt", wr_cnt, m_cnt[7:0]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      core_req = 0; dbg_req = 0; dbg_lock = 0;
      core_addr = '0; dbg_addr = '0; core_data = '0; dbg_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0;
      idle_inputs();
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      int cg, dg;
      reset_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1;

      // first write after reset release
      core_req = 1; core_addr = 4'd3; core_data = 8'h5A;
      cyc();
      chk("t1_we", rf_we, 1'b1);
      chk("t1_addr", rf_waddr, 4'd3);
      chk("t1_data", rf_wdata, 8'h5A);
      chk("t1_gnt", core_gnt, 1'b1);
      chk("t1_cnt", wr_cnt, 8'd1);
      core_req = 0;
      cyc();

      // both requests held: alternating grants
      do_reset();
      core_req = 1; dbg_req = 1; core_addr = 4'd1; dbg_addr = 4'd2;
      core_data = 8'h11; dbg_data = 8'h22;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         chk("t2_cgnt", core_gnt, (i == 1 || i == 5) ? 1'b1 : 1'b0);
         chk("t2_dgnt", dbg_gnt, (i == 3 || i == 7) ? 1'b1 : 1'b0);
      end
      chk("t2_cnt", wr_cnt, 8'd4);

      // lock session with the core request held
      do_reset();
      dbg_lock = 1; core_req = 1; core_addr = 4'd7; core_data = 8'h77;
      cyc();
      chk("t3_locked", locked, 1'b1);
      cg = 0; dg = 0;
      for (int i = 0; i < 3; i++) begin
         dbg_req = 1; dbg_addr = AW'($urandom); dbg_data = DW'($urandom);
         cyc();
         cg += int'(core_gnt); dg += int'(dbg_gnt);
         dbg_req = 0;
         cyc();
         cg += int'(core_gnt); dg += int'(dbg_gnt);
      end
      chk("t3_dgnts", dg, 3);
      chk("t3_cgnts", cg, 0);
      dbg_lock = 0;
      cyc();
      chk("t3_unlock", locked, 1'b0);
      cyc();
      chk("t3_core", core_gnt, 1'b1);
      core_req = 0;
      cyc();

      // dropping the lock during a lock write still completes it
      dbg_lock = 1;
      cyc();
      dbg_req = 1; dbg_addr = 4'd9; dbg_data = 8'h99;
      cyc();
      dbg_req = 0; dbg_lock = 0;
      chk("t4_wr", dbg_gnt, 1'b1);
      cyc();
      chk("t4_idle", locked, 1'b0);

      // counter wrap
      do_reset();
      core_req = 1;
      repeat (510) cyc();
      chk("t5_cnt255", wr_cnt, 8'd255);
      cyc();
      chk("t5_wrap", wr_cnt, 8'd0);
      chk("t5_we", rf_we, 1'b1);
      core_req = 0;
      cyc();

      // async reset during WR_DBG
      do_reset();
      dbg_req = 1; dbg_addr = 4'd5; dbg_data = 8'h55;
      cyc();
      chk("t6_pre", dbg_gnt, 1'b1);
      #2;
      reset_n = 0;
      #1;
      chk("t6_we", rf_we, 1'b0);
      chk("t6_gnt", dbg_gnt, 1'b0);
      model_reset();
      @(negedge clk);
      reset_n = 1;
      core_req = 1; dbg_req = 1;
      cyc();
      chk("t6_tie", core_gnt, 1'b1);

      // random traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (m_cgnt)          core_req = 1'($urandom_range(0, 1));
         else if (core_req)   core_req = ($urandom_range(0, 15) != 0);
         else                 core_req = 1'($urandom_range(0, 1));
         if (m_dgnt)          dbg_req = 1'($urandom_range(0, 1));
         else if (dbg_req)    dbg_req = ($urandom_range(0, 15) != 0);
         else                 dbg_req = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) dbg_lock = ~dbg_lock;
         core_addr = AW'($urandom); core_data = DW'($urandom);
         dbg_addr  = AW'($urandom); dbg_data  = DW'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
